// File: rtl/chan_mux_scan.sv
// chan_mux_scan: registered N-channel data selector.
// A selection register picks one of NCH flattened channels and registers it
// onto `out`, together with validity and illegal-index flags.
// Optional feature macro CHSEL_SCAN_EN adds an auto-scan mode. In this mode a
// round-robin scanner spends DWELL cycles on each channel and can be frozen
// with `hold`. Without the macro only IDLE and MANUAL exist, and `mode` and
// `hold` are ignored.
module chan_mux_scan #(
   parameter int WIDTH = 4,
   parameter int NCH   = 6,
   parameter int SELW  = 3,
   parameter int DWELL = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*WIDTH-1:0]   data_in,
   input  logic [SELW-1:0]        sel,
   input  logic                   sel_load,
   input  logic                   mode,
   input  logic                   hold,
   output logic [WIDTH-1:0]       out,
   output logic                   out_valid,
   output logic                   bad_sel,
   output logic [SELW-1:0]        cur_ch
);

   // Highest legal index; always representable in SELW bits, even when
   // NCH == 2**SELW.
   localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

`ifdef CHSEL_SCAN_EN
   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

   localparam int               CNT_W   = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;
   logic [SELW-1:0]  next_ch;
`else
   typedef enum logic [1:0] {IDLE, MANUAL} state_t;

   // Scan controls have no function in this build.
   logic unused_scan_ins;
   assign unused_scan_ins = mode ^ hold;
`endif

   state_t           state;
   logic             legal;
   logic [WIDTH-1:0] ch_data;

   assign legal = (cur_ch <= LAST_CH);

`ifdef CHSEL_SCAN_EN
   // Advance wraps after the last legal channel; an illegal index also
   // restarts at 0.
   assign next_ch = (cur_ch >= LAST_CH) ? '0 : cur_ch + SELW'(1);
`endif

   // Channel mux built as a compare per channel, so no part-select can fall
   // outside data_in for an illegal index.
   always_comb begin
      ch_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (cur_ch == SELW'(k)) ch_data = data_in[k*WIDTH +: WIDTH];
      end
   end

   // Control FSM: owns the state, the active channel and the dwell counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cur_ch <= '0;
`ifdef CHSEL_SCAN_EN
         cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (sel_load) begin
                  state  <= MANUAL;
                  cur_ch <= sel;
               end
`ifdef CHSEL_SCAN_EN
               else if (mode) begin
                  state  <= SCAN;
                  cur_ch <= '0;
                  cnt    <= '0;
               end
`endif
            end
            MANUAL: begin
               if (sel_load) cur_ch <= sel;
`ifdef CHSEL_SCAN_EN
               if (mode) begin
                  state <= SCAN;
                  cnt   <= '0;
                  if (!sel_load && !legal) cur_ch <= '0;
               end
`endif
            end
`ifdef CHSEL_SCAN_EN
            SCAN: begin
               if (!mode) begin
                  state <= MANUAL;
                  if (sel_load) cur_ch <= sel;
               end else if (sel_load) begin
                  cur_ch <= sel;
                  cnt    <= '0;
               end else if (!hold) begin
                  if (cnt == DW_LAST) begin
                     cnt    <= '0;
                     cur_ch <= next_ch;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: samples the channel selected by the current cur_ch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
         bad_sel   <= 1'b0;
      end else begin
         out       <= legal ? ch_data : '0;
         bad_sel   <= !legal;
         out_valid <= (state != IDLE) && legal;
      end
   end

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan (WIDTH=4, NCH=6, DWELL=4), channel k = k+1.
// The scan sequences are compiled only when CHSEL_SCAN_EN is defined.
module tb_chan_mux_scan;

   localparam int WIDTH = 4;
   localparam int NCH   = 6;
   localparam int SELW  = 3;
   localparam int DWELL = 4;
   localparam logic [NCH*WIDTH-1:0] BASE = 24'h654321;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b1;
   logic [NCH*WIDTH-1:0] data_in = BASE;
   logic [SELW-1:0]      sel = '0;
   logic                 sel_load = 1'b0;
   logic                 mode = 1'b0;
   logic                 hold = 1'b0;
   logic [WIDTH-1:0]     out;
   logic                 out_valid;
   logic                 bad_sel;
   logic [SELW-1:0]      cur_ch;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic            sl;
      logic [2:0]      sel;
      logic [3:0]      d3;
      logic [3:0]      eo;
      logic            ev;
      logic            eb;
      logic [2:0]      ec;
   } vec_t;

   vec_t tbl[16];

   always #5 clk = ~clk;

   chan_mux_scan #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel),
      .sel_load(sel_load), .mode(mode), .hold(hold), .out(out),
      .out_valid(out_valid), .bad_sel(bad_sel), .cur_ch(cur_ch)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] eo, input logic ev,
                      input logic eb, input logic [2:0] ec);
      vectors++;
      if (out !== eo || out_valid !== ev || bad_sel !== eb || cur_ch !== ec) begin
         miscompares++;
         $display("FAIL %s: got out=%h vld=%b bad=%b cur=%0d, expected out=%h vld=%b bad=%b cur=%0d",
                  nm, out, out_valid, bad_sel, cur_ch, eo, ev, eb, ec);
      end
   endtask

   initial begin
      //            sl  sel   d3     out    vld   bad   cur
      tbl[0]  = '{1'b0, 3'd0, 4'h4, 4'h1, 1'b0, 1'b0, 3'd0};  // idle
      tbl[1]  = '{1'b0, 3'd0, 4'h4, 4'h1, 1'b0, 1'b0, 3'd0};  // still idle
      tbl[2]  = '{1'b1, 3'd3, 4'h4, 4'h1, 1'b0, 1'b0, 3'd3};  // load 3
      tbl[3]  = '{1'b0, 3'd0, 4'h4, 4'h4, 1'b1, 1'b0, 3'd3};
      tbl[4]  = '{1'b0, 3'd0, 4'hA, 4'hA, 1'b1, 1'b0, 3'd3};  // live data
      tbl[5]  = '{1'b0, 3'd0, 4'h4, 4'h4, 1'b1, 1'b0, 3'd3};
      tbl[6]  = '{1'b1, 3'd7, 4'h4, 4'h4, 1'b1, 1'b0, 3'd7};  // illegal 7
      tbl[7]  = '{1'b0, 3'd0, 4'h4, 4'h0, 1'b0, 1'b1, 3'd7};
      tbl[8]  = '{1'b1, 3'd0, 4'h4, 4'h0, 1'b0, 1'b1, 3'd0};  // back to 0
      tbl[9]  = '{1'b0, 3'd0, 4'h4, 4'h1, 1'b1, 1'b0, 3'd0};
      tbl[10] = '{1'b1, 3'd5, 4'h4, 4'h1, 1'b1, 1'b0, 3'd5};  // last legal
      tbl[11] = '{1'b0, 3'd0, 4'h4, 4'h6, 1'b1, 1'b0, 3'd5};
      tbl[12] = '{1'b1, 3'd6, 4'h4, 4'h6, 1'b1, 1'b0, 3'd6};  // first illegal
      tbl[13] = '{1'b0, 3'd0, 4'h4, 4'h0, 1'b0, 1'b1, 3'd6};
      tbl[14] = '{1'b1, 3'd0, 4'h4, 4'h0, 1'b0, 1'b1, 3'd0};
      tbl[15] = '{1'b0, 3'd0, 4'h4, 4'h1, 1'b1, 1'b0, 3'd0};

      // Reset with random inputs
      #1 rst_n = 1'b0;
      data_in  = {$urandom, $urandom};
      sel      = SELW'($urandom);
      sel_load = 1'($urandom);
      mode     = 1'($urandom);
      hold     = 1'($urandom);
      #1 chk("reset_async", 4'h0, 1'b0, 1'b0, 3'd0);
      tick();
      tick();
      chk("reset_held", 4'h0, 1'b0, 1'b0, 3'd0);
      data_in  = BASE;
      sel      = '0;
      sel_load = 1'b0;
      mode     = 1'b0;
      hold     = 1'b0;
      #2 rst_n = 1'b1;

      // Manual / illegal-select table
      for (int i = 0; i < 16; i++) begin
         sel_load = tbl[i].sl;
         sel      = tbl[i].sel;
         data_in[3*WIDTH +: WIDTH] = tbl[i].d3;
         tick();
         chk($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ev, tbl[i].eb, tbl[i].ec);
      end
      sel_load = 1'b0;

      // Async reset between edges
      sel_load = 1'b1; sel = 3'd2;
      tick();
      sel_load = 1'b0;
      chk("pre_rst_load", 4'h1, 1'b1, 1'b0, 3'd2);
      tick();
      chk("pre_rst_out", 4'h3, 1'b1, 1'b0, 3'd2);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_mid", 4'h0, 1'b0, 1'b0, 3'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_idle0", 4'h1, 1'b0, 1'b0, 3'd0);
      tick();
      chk("post_rst_idle1", 4'h1, 1'b0, 1'b0, 3'd0);

`ifdef CHSEL_SCAN_EN
      // IDLE -> SCAN from channel 0
      mode = 1'b1;
      tick();
      chk("idle2scan", 4'h1, 1'b0, 1'b0, 3'd0);
      tick();
      chk("scan_ch0", 4'h1, 1'b1, 1'b0, 3'd0);
      // sel_load with mode=0 -> MANUAL at sel
      mode = 1'b0; sel_load = 1'b1; sel = 3'd4;
      tick();
      sel_load = 1'b0;
      chk("scan2man_sel", 4'h1, 1'b1, 1'b0, 3'd4);
      tick();
      chk("man_ch4", 4'h5, 1'b1, 1'b0, 3'd4);

      // Scan with wrap from channel 4
      mode = 1'b1;
      tick();
      chk("scan_e0", 4'h5, 1'b1, 1'b0, 3'd4);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("scan_wrap%0d", i), 4'(((4 + i / DWELL) % NCH) + 1), 1'b1, 1'b0,
             3'((4 + (i + 1) / DWELL) % NCH));
      end

      // Jump to 1, two cycles, hold three, release
      sel_load = 1'b1; sel = 3'd1;
      tick();
      sel_load = 1'b0;
      chk("jump1", 4'h3, 1'b1, 1'b0, 3'd1);
      for (int j = 0; j < 7; j++) begin
         hold = (j >= 1 && j <= 3);
         tick();
         chk($sformatf("hold%0d", j), 4'h2, 1'b1, 1'b0, (j < 6) ? 3'd1 : 3'd2);
      end

      // sel_load during hold wins, fresh dwell, wrap 5 -> 0
      hold = 1'b1; sel_load = 1'b1; sel = 3'd5;
      tick();
      sel_load = 1'b0; hold = 1'b0;
      chk("jump_in_hold", 4'h3, 1'b1, 1'b0, 3'd5);
      for (int j = 1; j <= 4; j++) begin
         tick();
         chk($sformatf("dwell5_%0d", j), 4'h6, 1'b1, 1'b0, (j < 4) ? 3'd5 : 3'd0);
      end

      // Back to MANUAL: channel must stop advancing
      mode = 1'b0;
      for (int j = 0; j < 6; j++) tick();
      chk("manual_frozen", 4'h1, 1'b1, 1'b0, 3'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
